// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent TX and RX paths on one clock.
// Optional stop-bit checking on RX under `UART_RX_FRAME_CHECK_EN.
module uart_txrx #(
    parameter int SYS_CLOCK     = 50000000,
    parameter int UART_BAUDRATE = 115200
) (
    input  logic       i_SysClock,
    input  logic       i_ResetN,
    input  logic       i_TxValid,
    input  logic [7:0] i_TxByte,
    output logic       o_TxSerial,
    output logic       o_TxDone,
    input  logic       i_RxSerial,
    output logic [7:0] o_RxByte,
    output logic       o_RxDone
`ifdef UART_RX_FRAME_CHECK_EN
  , output logic       o_RxFrameErr
`endif
);

    localparam int CLKS_PER_BIT = SYS_CLOCK / UART_BAUDRATE;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
`ifdef UART_RX_FRAME_CHECK_EN
      , RX_BREAK
`endif
    } rx_state_t;

    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_data;

    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_hold;
    logic          rx_meta;
    logic          rx_sync;

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_idx     <= '0;
            tx_data    <= '0;
            o_TxSerial <= 1'b1;
            o_TxDone   <= 1'b0;
        end else begin
            unique case (tx_state)
                TX_IDLE: begin
                    o_TxSerial <= 1'b1;
                    o_TxDone   <= 1'b0;
                    tx_cnt     <= '0;
                    tx_idx     <= '0;
                    if (i_TxValid) begin
                        tx_data  <= i_TxByte;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    o_TxSerial <= 1'b0;
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    o_TxSerial <= tx_data[tx_idx];
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx_state <= TX_STOP;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    o_TxSerial <= 1'b1;
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        o_TxDone <= 1'b1;
                        tx_state <= TX_DONE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DONE: begin
                    o_TxSerial <= 1'b1;
                    o_TxDone   <= 1'b0;
                    tx_state   <= TX_IDLE;
                end
                default: begin
                    o_TxSerial <= 1'b1;
                    o_TxDone   <= 1'b0;
                    tx_state   <= TX_IDLE;
                end
            endcase
        end
    end

    // Line is asynchronous; only rx_sync feeds the RX FSM.
    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_RxSerial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_hold  <= '0;
            o_RxByte <= '0;
            o_RxDone <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
            o_RxFrameErr <= 1'b0;
`endif
        end else begin
            unique case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_idx <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            o_RxDone <= 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
                            o_RxFrameErr <= 1'b0;
`endif
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt  <= '0;
                        rx_hold <= {rx_sync, rx_hold[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt <= '0;
`ifdef UART_RX_FRAME_CHECK_EN
                        if (rx_sync) begin
                            o_RxByte <= rx_hold;
                            o_RxDone <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            o_RxFrameErr <= 1'b1;
                            rx_state     <= RX_BREAK;
                        end
`else
                        o_RxByte <= rx_hold;
                        o_RxDone <= 1'b1;
                        rx_state <= RX_IDLE;
`endif
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_FRAME_CHECK_EN
                // Wait out a held-low line so it is not taken as a new start.
                RX_BREAK: begin
                    if (rx_sync) rx_state <= RX_IDLE;
                end
`endif
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txrx.sv
// Directed self-checking bench for uart_txrx (loopback and driven RX line).
// Build with +define+UART_RX_FRAME_CHECK_EN to also exercise framing errors.
module tb_uart_txrx;

    localparam int CPB = 434;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_serial;
    logic       tx_done;
    logic       rx_serial;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       loop = 1'b1;
    logic       tb_rx = 1'b1;
`ifdef UART_RX_FRAME_CHECK_EN
    logic       rx_ferr;
`endif

    int checks = 0;
    int errors = 0;

    assign rx_serial = loop ? tx_serial : tb_rx;

    always #5 clk = ~clk;

    uart_txrx dut (
        .i_SysClock (clk),
        .i_ResetN   (rst_n),
        .i_TxValid  (tx_valid),
        .i_TxByte   (tx_byte),
        .o_TxSerial (tx_serial),
        .o_TxDone   (tx_done),
        .i_RxSerial (rx_serial),
        .o_RxByte   (rx_byte),
        .o_RxDone   (rx_done)
`ifdef UART_RX_FRAME_CHECK_EN
      , .o_RxFrameErr (rx_ferr)
`endif
    );

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic tx_frame(input logic [7:0] b, input bit disturb,
                            input string name);
        int fall;
        int first;
        int pulses;
        logic rx_at_done;
        logic low_end;
        logic [9:0] got;
        logic [9:0] want;
        fall = -1;
        first = -1;
        pulses = 0;
        rx_at_done = 1'b0;
        low_end = 1'b1;
        got = '0;
        want = {1'b1, b, 1'b0};
        @(negedge clk);
        tx_byte = b;
        tx_valid = 1'b1;
        for (int t = 1; t <= 10 && fall < 0; t++) begin
            @(negedge clk);
            if (t == 1) tx_valid = 1'b0;
            if (tx_serial === 1'b0) fall = t;
        end
        tx_valid = 1'b0;
        checks++;
        if (fall != 2) begin
            errors++;
            $display("FAIL %s start_latency got %0d want 2", name, fall);
        end
        if (fall >= 0) begin
            for (int c = 0; c <= 10 * CPB + 20; c++) begin
                if (c > 0) @(negedge clk);
                if (disturb && c == 2000) begin
                    tx_valid = 1'b1;
                    tx_byte = 8'hA3;
                end
                if (disturb && c == 2100) tx_valid = 1'b0;
                if (c == CPB - 1) low_end = tx_serial;
                if (c % CPB == CPB / 2 && c < 10 * CPB)
                    got[c / CPB] = tx_serial;
                if (tx_done === 1'b1) begin
                    pulses++;
                    if (first < 0) begin
                        first = c;
                        rx_at_done = rx_done;
                    end
                end
            end
            checks++;
            if (low_end !== 1'b0) begin
                errors++;
                $display("FAIL %s start_width line %b at clk %0d want 0",
                         name, low_end, CPB - 1);
            end
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s line_bits got %b want %b", name, got, want);
            end
            checks++;
            if (pulses != 1) begin
                errors++;
                $display("FAIL %s done_pulses got %0d want 1", name, pulses);
            end
            checks++;
            if (first < 10 * CPB - 1 || first > 10 * CPB + 1) begin
                errors++;
                $display("FAIL %s done_time got %0d want %0d+-1",
                         name, first, 10 * CPB);
            end
            checks++;
            if (rx_at_done !== 1'b1) begin
                errors++;
                $display("FAIL %s rxdone_at_txdone got %b want 1",
                         name, rx_at_done);
            end
            checks++;
            if (rx_byte !== b) begin
                errors++;
                $display("FAIL %s rx_byte got %h want %h", name, rx_byte, b);
            end
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input int bitclk,
                            input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            tb_rx = fr[k];
            repeat (bitclk) @(negedge clk);
        end
        tb_rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_serial !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_serial got %b want 1", tx_serial);
        end
        checks++;
        if (tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_done got %b want 0", tx_done);
        end
        checks++;
        if (rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_byte got %h want 00", rx_byte);
        end
        checks++;
        if (rx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_done got %b want 0", rx_done);
        end
`ifdef UART_RX_FRAME_CHECK_EN
        checks++;
        if (rx_ferr !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_ferr got %b want 0", rx_ferr);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback_55();
        loop = 1'b1;
        pulse_reset();
        tx_frame(8'h55, 1'b0, "lb55");
    endtask

    task automatic test_patterns();
        logic [7:0] r;
        pulse_reset();
        tx_frame(8'h00, 1'b0, "lb00");
        pulse_reset();
        tx_frame(8'hFF, 1'b0, "lbFF");
        for (int i = 0; i < 10; i++) begin
            r = 8'($urandom_range(0, 255));
            pulse_reset();
            tx_frame(r, 1'b0, $sformatf("lbrand%0d", i));
        end
    endtask

    task automatic test_valid_midframe();
        pulse_reset();
        tx_frame(8'h3C, 1'b1, "midvalid");
    endtask

    task automatic test_reset_middata();
        int fall;
        int txd;
        int rxd;
        fall = 0;
        txd = 0;
        rxd = 0;
        pulse_reset();
        @(negedge clk);
        tx_byte = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int t = 0; t < 10 && fall == 0; t++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) fall = 1;
        end
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_serial !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_tx_serial got %b want 1", tx_serial);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (tx_done === 1'b1) txd++;
            if (rx_done === 1'b1) rxd++;
        end
        checks++;
        if (txd != 0) begin
            errors++;
            $display("FAIL rstmid_tx_done got %0d pulses want 0", txd);
        end
        checks++;
        if (rxd != 0) begin
            errors++;
            $display("FAIL rstmid_rx_done got %0d high want 0", rxd);
        end
        tx_frame(8'h81, 1'b0, "after_rst81");
    endtask

    task automatic test_glitch();
        loop = 1'b0;
        tb_rx = 1'b1;
        repeat (5) @(negedge clk);
        tb_rx = 1'b0;
        repeat (100) @(negedge clk);
        tb_rx = 1'b1;
        repeat (600) @(negedge clk);
        checks++;
        if (rx_done !== 1'b1) begin
            errors++;
            $display("FAIL glitch_rx_done got %b want 1", rx_done);
        end
        checks++;
        if (rx_byte !== 8'h81) begin
            errors++;
            $display("FAIL glitch_rx_byte got %h want 81", rx_byte);
        end
    endtask

    task automatic test_baud_mismatch();
        loop = 1'b0;
        drive_rx(8'hA5, 425, 1'b1);
        repeat (50) @(negedge clk);
        checks++;
        if (rx_byte !== 8'hA5) begin
            errors++;
            $display("FAIL fast_baud_rx_byte got %h want a5", rx_byte);
        end
        checks++;
        if (rx_done !== 1'b1) begin
            errors++;
            $display("FAIL fast_baud_rx_done got %b want 1", rx_done);
        end
    endtask

`ifdef UART_RX_FRAME_CHECK_EN
    task automatic test_frame_err();
        loop = 1'b0;
        drive_rx(8'h12, CPB, 1'b0);
        repeat (100) @(negedge clk);
        checks++;
        if (rx_ferr !== 1'b1) begin
            errors++;
            $display("FAIL ferr_flag got %b want 1", rx_ferr);
        end
        checks++;
        if (rx_done !== 1'b0) begin
            errors++;
            $display("FAIL ferr_rx_done got %b want 0", rx_done);
        end
        checks++;
        if (rx_byte !== 8'hA5) begin
            errors++;
            $display("FAIL ferr_rx_byte got %h want a5", rx_byte);
        end
        drive_rx(8'h34, CPB, 1'b1);
        repeat (50) @(negedge clk);
        checks++;
        if (rx_ferr !== 1'b0) begin
            errors++;
            $display("FAIL ferr_clear got %b want 0", rx_ferr);
        end
        checks++;
        if (rx_byte !== 8'h34) begin
            errors++;
            $display("FAIL ferr_next_byte got %h want 34", rx_byte);
        end
        checks++;
        if (rx_done !== 1'b1) begin
            errors++;
            $display("FAIL ferr_next_done got %b want 1", rx_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_loopback_55();
        test_patterns();
        test_valid_midframe();
        test_reset_middata();
        test_glitch();
        test_baud_mismatch();
`ifdef UART_RX_FRAME_CHECK_EN
        test_frame_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- Full-duplex 8N1 UART block: one transmitter path and one receiver path, sharing a clock and reset.
- Used as the serial front-end between a byte-parallel system bus and a TX/RX pin pair.
- TX and RX are independent; a loopback (o_TxSerial to i_RxSerial) returns every transmitted byte unchanged.

Parameters:
- SYS_CLOCK, 50000000, system clock frequency in Hz.
- UART_BAUDRATE, 115200, serial bit rate in baud.
- CLKS_PER_BIT (localparam): SYS_CLOCK/UART_BAUDRATE, truncating integer division. Default 434.

Ports:
- i_SysClock  input  1  system clock; all logic on its rising edge.
- i_ResetN  input  1  asynchronous, active-low reset.
- i_TxValid  input  1  transmit request, sampled each clock.
- i_TxByte  input  8  byte to send, latched when the request is accepted.
- o_TxSerial  output  1  serial TX line, idle high.
- o_TxDone  output  1  one-cycle pulse when a frame's stop bit completes.
- i_RxSerial  input  1  serial RX line, asynchronous to the clock.
- o_RxByte  output  8  last received byte.
- o_RxDone  output  1  received-byte-available flag.

Behaviour:
- Reset, asynchronous while i_ResetN=0:
  - o_TxSerial=1, o_TxDone=0, o_RxByte=0, o_RxDone=0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset asserted mid-frame aborts the frame immediately; the TX line returns high.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts exactly CLKS_PER_BIT clocks; a frame is 10*CLKS_PER_BIT clocks.
- TX FSM states: IDLE, START, DATA, STOP, DONE.
  - IDLE: line high. i_TxValid=1 latches i_TxByte and moves to START. o_TxSerial goes low on the clock edge after the one that samples i_TxValid.
  - START and DATA: bit counter 0..7; shift out the latched byte.
  - STOP: drive 1 for CLKS_PER_BIT clocks.
  - DONE: o_TxDone=1 for exactly one clock, line stays high, then return to IDLE.
  - i_TxValid is ignored in every state except IDLE. Changes to i_TxByte during a frame have no effect.
  - A request held high in the DONE cycle is not accepted until the next IDLE cycle.
- RX path:
  - i_RxSerial passes through a 2-flop synchronizer; all RX logic uses the synchronized signal.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a low level on the synchronized line moves to START.
  - START: at count CLKS_PER_BIT/2, re-sample. If the line is high, treat it as a glitch and return to IDLE. If low, clear o_RxDone and go to DATA.
  - DATA: sample at mid-bit, every CLKS_PER_BIT clocks from the start-bit centre. Shift LSB-first into a holding register.
  - STOP: sample at mid-stop-bit. Copy the holding register to o_RxByte, set o_RxDone=1, and return to IDLE.
  - o_RxDone is a level flag. It stays 1 until the next validated start bit or reset.
  - o_RxByte holds its value until the next completed frame.
- Timing: RX detection lag equals the synchronizer depth plus the half-bit offset. After a loopback frame, o_RxDone is already 1 when o_TxDone pulses.
- Mismatched clocks: a ±2% baud mismatch must still decode correctly, because sampling is at mid-bit.

Optional Feature:
- Macro: UART_RX_FRAME_CHECK_EN.
- When defined:
  - Adds output o_RxFrameErr (1 bit, reset 0).
  - If the stop-bit sample is 0, o_RxByte is not updated, o_RxDone stays 0, and o_RxFrameErr=1.
  - o_RxFrameErr clears at the next validated start bit.
  - After a framing error, RX returns to IDLE only once the line has been sampled high.
- When undefined:
  - There is no o_RxFrameErr port.
  - The stop bit is sampled but ignored; the byte is always delivered with o_RxDone=1.

Test Plan:
- Loopback 0x55 with default parameters:
  - o_TxSerial low for 434 clocks after TxValid; data pattern 1,0,1,0,1,0,1,0 at 434 clocks per bit.
  - o_TxDone pulses once, 4340±1 clocks after the start bit began.
  - o_RxByte=0x55 and o_RxDone=1.
- Loopback 0x00, 0xFF and 10 random bytes, with reset pulsed between frames: o_RxByte equals i_TxByte every time; no extra o_TxDone pulses.
- i_TxValid re-asserted with 0xA3 mid-frame of 0x3C: only 0x3C is transmitted and received, and exactly one o_TxDone pulse occurs.
- i_ResetN pulsed low during DATA of a TX frame:
  - o_TxSerial=1 immediately and o_TxDone never fires.
  - o_RxDone stays 0, with RX not left stuck in a partial frame.
  - Next frame 0x81 is received correctly.
- i_RxSerial low glitch of 100 clocks (<217): no start is accepted, o_RxDone and o_RxByte are unchanged.
- With UART_RX_FRAME_CHECK_EN: drive frame 0x12 with stop bit 0 → o_RxFrameErr=1, o_RxDone=0, o_RxByte unchanged. A following valid 0x34 → o_RxFrameErr=0, o_RxByte=0x34, o_RxDone=1.
